// File: rtl/apb_controller.sv
// AHB-to-APB bridge controller: accepts one decoded AHB transfer at a time and
// sequences it through the APB setup/enable phases.
module apb_controller (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        valid,
    input  logic [31:0] Haddr,
    input  logic        Hwrite,
    input  logic [2:0]  Hselx,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic [2:0]  Psel,
    output logic        Penable,
    output logic        Pwrite,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Hreadyout,
    output logic [31:0] Hrdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WWAIT   = 3'd1;
    localparam logic [2:0] RSETUP  = 3'd2;
    localparam logic [2:0] WSETUP  = 3'd3;
    localparam logic [2:0] RENABLE = 3'd4;
    localparam logic [2:0] WENABLE = 3'd5;

    logic [2:0]  state;
    logic [2:0]  next_state;
    logic        accept;
    logic [31:0] addr_p0;
    logic        write_p0;
    logic [2:0]  sel_p0;
    logic [31:0] addr_nx;
    logic        write_nx;
    logic [2:0]  sel_nx;

    always_comb begin
        Hreadyout = (state == IDLE) || (state == RENABLE) || (state == WENABLE);
        Hrdata    = (state == RENABLE) ? Prdata : 32'h0;
        accept    = valid && (Hselx != 3'b000) && Hreadyout;
    end

    // A transfer accepted this cycle goes straight to the setup phase for reads,
    // so the APB registers must see the live request rather than the captured copy.
    always_comb begin
        addr_nx  = accept ? Haddr  : addr_p0;
        write_nx = accept ? Hwrite : write_p0;
        sel_nx   = accept ? Hselx  : sel_p0;
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE, RENABLE, WENABLE: begin
                if (accept) next_state = Hwrite ? WWAIT : RSETUP;
                else        next_state = IDLE;
            end
            WWAIT:   next_state = WSETUP;
            RSETUP:  next_state = RENABLE;
            WSETUP:  next_state = WENABLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Address-phase capture
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            addr_p0  <= 32'h0;
            write_p0 <= 1'b0;
            sel_p0   <= 3'b000;
        end else if (accept) begin
            addr_p0  <= Haddr;
            write_p0 <= Hwrite;
            sel_p0   <= Hselx;
        end
    end

    // APB outputs registered from the next state so they only move on a clock edge
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            Psel    <= 3'b000;
            Penable <= 1'b0;
            Pwrite  <= 1'b0;
            Paddr   <= 32'h0;
            Pwdata  <= 32'h0;
        end else begin
            case (next_state)
                RSETUP, WSETUP: begin
                    Psel    <= sel_nx;
                    Paddr   <= addr_nx;
                    Pwrite  <= write_nx;
                    Penable <= 1'b0;
                end
                RENABLE, WENABLE: begin
                    Penable <= 1'b1;
                end
                default: begin
                    Psel    <= 3'b000;
                    Penable <= 1'b0;
                end
            endcase
            if (state == WWAIT) Pwdata <= Hwdata;
        end
    end

endmodule

// File: tb/tb_apb_controller.sv
// Self-checking bench for apb_controller: per-cycle expectations are queued as
// stimulus is driven and compared on the falling edge.
module tb_apb_controller;

    logic        Hclk;
    logic        Hresetn;
    logic        valid;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [2:0]  Hselx;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic [2:0]  Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;

    apb_controller dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .valid     (valid),
        .Haddr     (Haddr),
        .Hwrite    (Hwrite),
        .Hselx     (Hselx),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .Psel      (Psel),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Hreadyout (Hreadyout),
        .Hrdata    (Hrdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    typedef struct packed {
        logic [2:0]  psel;
        logic        pen;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        hready;
        logic [31:0] hrdata;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Values the APB side is expected to hold between transfers
    logic [31:0] m_paddr  = 32'h0;
    logic        m_pwrite = 1'b0;
    logic [31:0] m_pwdata = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] ps, input logic pe, input logic hr,
                                input logic [31:0] rd);
        exp_t e;
        e.psel   = ps;
        e.pen    = pe;
        e.pwrite = m_pwrite;
        e.paddr  = m_paddr;
        e.pwdata = m_pwdata;
        e.hready = hr;
        e.hrdata = rd;
        return e;
    endfunction

    // Drive one cycle of inputs, queue what the DUT must show this cycle, advance.
    task automatic step(input logic v, input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] wd, input logic [31:0] prd, input exp_t e);
        valid  = v;
        Hwrite = w;
        Haddr  = a;
        Hselx  = s;
        Hwdata = wd;
        Prdata = prd;
        sb.push_back(e);
        @(posedge Hclk);
        #1;
    endtask

    always @(negedge Hclk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("psel",    32'(Psel),      32'(e.psel));
            check("penable", 32'(Penable),   32'(e.pen));
            check("pwrite",  32'(Pwrite),    32'(e.pwrite));
            check("paddr",   Paddr,          e.paddr);
            check("pwdata",  Pwdata,         e.pwdata);
            check("hready",  32'(Hreadyout), 32'(e.hready));
            check("hrdata",  Hrdata,         e.hrdata);
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_psel"},   32'(Psel),      32'h0);
        check({tag, "_pen"},    32'(Penable),   32'h0);
        check({tag, "_pwrite"}, 32'(Pwrite),    32'h0);
        check({tag, "_paddr"},  Paddr,          32'h0);
        check({tag, "_pwdata"}, Pwdata,         32'h0);
        check({tag, "_hready"}, 32'(Hreadyout), 32'h1);
        check({tag, "_hrdata"}, Hrdata,         32'h0);
    endtask

    initial begin
        valid   = 1'b0;
        Hwrite  = 1'b0;
        Haddr   = 32'h0;
        Hselx   = 3'b000;
        Hwdata  = 32'h0;
        Prdata  = 32'h0;
        Hresetn = 1'b1;
        #1 Hresetn = 1'b0;
        #1 check_reset_vals("rst_async");
        @(posedge Hclk);
        @(posedge Hclk);
        #1 check_reset_vals("rst_held");
        #2 Hresetn = 1'b1;
        @(posedge Hclk);
        #1;

        // Single read
        step(1, 0, 32'h8000_0010, 3'b001, 32'h0, 32'hA5A5_1234, mk(3'b000, 0, 1, 32'h0));
        m_paddr = 32'h8000_0010; m_pwrite = 0;
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'hA5A5_1234, mk(3'b001, 0, 0, 32'h0));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'hA5A5_1234, mk(3'b001, 1, 1, 32'hA5A5_1234));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'hA5A5_1234, mk(3'b000, 0, 1, 32'h0));

        // Single write
        step(1, 1, 32'h8400_0004, 3'b010, 32'h0, 32'h1111_2222, mk(3'b000, 0, 1, 32'h0));
        step(0, 0, 32'h0, 3'b000, 32'hDEAD_BEEF, 32'h1111_2222, mk(3'b000, 0, 0, 32'h0));
        m_paddr = 32'h8400_0004; m_pwrite = 1; m_pwdata = 32'hDEAD_BEEF;
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h1111_2222, mk(3'b010, 0, 0, 32'h0));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h1111_2222, mk(3'b010, 1, 1, 32'h0));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h1111_2222, mk(3'b000, 0, 1, 32'h0));

        // Back-to-back read -> write -> read
        step(1, 0, 32'h8000_0020, 3'b100, 32'h0, 32'h0, mk(3'b000, 0, 1, 32'h0));
        m_paddr = 32'h8000_0020; m_pwrite = 0;
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h0, mk(3'b100, 0, 0, 32'h0));
        step(1, 1, 32'h8800_0008, 3'b001, 32'h0, 32'h0BAD_F00D, mk(3'b100, 1, 1, 32'h0BAD_F00D));
        step(0, 0, 32'h0, 3'b000, 32'h1234_5678, 32'h0, mk(3'b000, 0, 0, 32'h0));
        m_paddr = 32'h8800_0008; m_pwrite = 1; m_pwdata = 32'h1234_5678;
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h0, mk(3'b001, 0, 0, 32'h0));
        step(1, 0, 32'h8000_0030, 3'b010, 32'h0, 32'h0, mk(3'b001, 1, 1, 32'h0));
        m_paddr = 32'h8000_0030; m_pwrite = 0;
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h0, mk(3'b010, 0, 0, 32'h0));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'hCAFE_0001, mk(3'b010, 1, 1, 32'hCAFE_0001));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'hCAFE_0001, mk(3'b000, 0, 1, 32'h0));

        // valid with no peripheral selected is ignored
        step(1, 0, 32'h9000_0000, 3'b000, 32'h0, 32'h0, mk(3'b000, 0, 1, 32'h0));
        step(1, 1, 32'h9000_0004, 3'b000, 32'h0, 32'h0, mk(3'b000, 0, 1, 32'h0));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h0, mk(3'b000, 0, 1, 32'h0));

        // valid pulsed during RSETUP is ignored
        step(1, 0, 32'h8000_0040, 3'b001, 32'h0, 32'h0, mk(3'b000, 0, 1, 32'h0));
        m_paddr = 32'h8000_0040; m_pwrite = 0;
        step(1, 1, 32'hBBBB_0000, 3'b100, 32'h0, 32'h0, mk(3'b001, 0, 0, 32'h0));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h5555_AAAA, mk(3'b001, 1, 1, 32'h5555_AAAA));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h0, mk(3'b000, 0, 1, 32'h0));

        // Reset dropped during WSETUP
        step(1, 1, 32'h8400_0100, 3'b010, 32'h0, 32'h0, mk(3'b000, 0, 1, 32'h0));
        step(0, 0, 32'h0, 3'b000, 32'hFEED_FACE, 32'h0, mk(3'b000, 0, 0, 32'h0));
        #1;
        check("wsetup_psel",   32'(Psel),      32'h2);
        check("wsetup_pwdata", Pwdata,         32'hFEED_FACE);
        check("wsetup_hready", 32'(Hreadyout), 32'h0);
        Hresetn = 1'b0;
        #1 check_reset_vals("rst_mid");
        @(posedge Hclk);
        #1 check_reset_vals("rst_mid_held");
        #2 Hresetn = 1'b1;
        @(posedge Hclk);
        #1;
        m_paddr = 32'h0; m_pwrite = 0; m_pwdata = 32'h0;

        // Read after reset recovery
        step(1, 0, 32'h8000_0050, 3'b100, 32'h0, 32'h0, mk(3'b000, 0, 1, 32'h0));
        m_paddr = 32'h8000_0050;
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h0, mk(3'b100, 0, 0, 32'h0));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h7777_8888, mk(3'b100, 1, 1, 32'h7777_8888));
        step(0, 0, 32'h0, 3'b000, 32'h0, 32'h0, mk(3'b000, 0, 1, 32'h0));

        @(negedge Hclk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/apb_controller.md
APB_CONTROLLER -- requirements
Module: apb_controller

Interface
REQ-001 SHALL have port Hclk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port Hresetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port valid, input, 1, a decoded AHB transfer is present in this cycle's address phase.
REQ-004 SHALL have port Haddr, input, 32, AHB address, sampled with valid.
REQ-005 SHALL have port Hwrite, input, 1, 1 = write and 0 = read, sampled with valid.
REQ-006 SHALL have port Hselx, input, 3, one-hot peripheral select, sampled with valid.
REQ-007 SHALL have port Hwdata, input, 32, AHB write data, valid in the data phase.
REQ-008 SHALL have port Prdata, input, 32, read data returned by the APB peripheral.
REQ-009 SHALL have port Psel, output, 3, APB peripheral select.
REQ-010 SHALL have port Penable, output, 1, APB enable strobe.
REQ-011 SHALL have port Pwrite, output, 1, APB direction.
REQ-012 SHALL have port Paddr, output, 32, APB address.
REQ-013 SHALL have port Pwdata, output, 32, APB write data.
REQ-014 SHALL have port Hreadyout, output, 1, transfer-complete / ready-for-next flag to the AHB side.
REQ-015 SHALL have port Hrdata, output, 32, read data to the AHB side.

Function
REQ-016 SHALL implement a six-state FSM: IDLE, WWAIT, RSETUP, WSETUP, RENABLE, WENABLE.
REQ-017 SHALL define a request as accepted only when valid=1, Hselx!=0 and Hreadyout=1 in the same cycle; valid=1 with Hselx=0 SHALL be ignored.
REQ-018 SHALL, on acceptance, capture Haddr, Hwrite and Hselx into internal registers.
REQ-019 SHALL use these IDLE transitions: accepted read -> RSETUP; accepted write -> WWAIT; otherwise stay in IDLE.
REQ-020 SHALL make WWAIT last exactly one cycle, capture Hwdata into Pwdata at its end, and then go to WSETUP.
REQ-021 SHALL make RSETUP and WSETUP last one cycle each, driving Psel=captured sel, Paddr=captured addr, Pwrite=captured write, Penable=0; exits are RSETUP -> RENABLE and WSETUP -> WENABLE.
REQ-022 SHALL make RENABLE and WENABLE last one cycle each, holding Psel, Paddr and Pwrite and driving Penable=1.
REQ-023 SHALL use these exits from RENABLE and WENABLE: accepted read -> RSETUP; accepted write -> WWAIT; otherwise -> IDLE. Back-to-back transfers have no idle gap.
REQ-024 SHALL drive Hreadyout=1 in IDLE, RENABLE and WENABLE, and Hreadyout=0 in WWAIT, RSETUP and WSETUP.
REQ-025 SHALL drive Hrdata=Prdata combinationally in RENABLE and Hrdata=0 in every other state.
REQ-026 SHALL register Psel, Penable, Pwrite, Paddr and Pwdata from the next-state value, so they change only on a Hclk edge and are glitch-free.
REQ-027 SHALL drive Psel=0 and Penable=0 in IDLE and WWAIT; Paddr, Pwrite and Pwdata hold their last values there.
REQ-028 SHALL have these latencies from the acceptance cycle: read = 2 cycles (RSETUP, RENABLE); write = 3 cycles (WWAIT, WSETUP, WENABLE).
REQ-029 SHALL ignore valid, Haddr, Hwrite and Hselx while Hreadyout=0, with no capture and no state change from them.
REQ-030 SHALL pass Hselx through unchecked for one-hot violations; Psel equals the captured value.

Reset
REQ-031 SHALL, while Hresetn=0, immediately and asynchronously force: state=IDLE, Psel=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1, Hrdata=0.
REQ-032 SHALL, when Hresetn asserts mid-transfer in any state, abort the transfer with no completion and resume from IDLE on the first Hclk edge after release.

Verification
REQ-033 SHALL cover a single read: valid=1, Hwrite=0, Haddr=0x8000_0010, Hselx=001 -> next cycle Psel=001, Paddr=0x8000_0010, Penable=0, Hreadyout=0 -> following cycle Penable=1, Hreadyout=1, Hrdata=Prdata (e.g. 0xA5A5_1234).
REQ-034 SHALL cover a single write: valid=1, Hwrite=1, Haddr=0x8400_0004, Hselx=010, then Hwdata=0xDEAD_BEEF -> WWAIT with Hreadyout=0 -> WSETUP with Pwdata=0xDEAD_BEEF, Pwrite=1 -> WENABLE with Penable=1, Hreadyout=1.
REQ-035 SHALL cover back-to-back read then write: valid held high in RENABLE -> next cycle is WWAIT, and Psel=0 for exactly one cycle before WSETUP.
REQ-036 SHALL cover valid=1 with Hselx=000 -> FSM stays IDLE, Psel=0, Hreadyout=1.
REQ-037 SHALL cover Hresetn dropped during WSETUP -> outputs at reset values within the same cycle; after release, a new read completes normally.
REQ-038 SHALL cover valid pulsed while in RSETUP -> the pulse is ignored and the FSM returns to IDLE after RENABLE.
